// File: rtl/booth_mult_scheduler_if.sv
// Bundles the requester, multiplier-core and response signals of the shared
// Booth multiplier scheduler. The scheduler uses the slave view; the
// environment (clients, core and response sink) uses the master view.
interface booth_mult_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 4
);
  localparam int unsigned ID_W   = $clog2(NUM_REQ);
  localparam int unsigned PROD_W = 2 * DATA_W;

  // Requester side
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_ready;

  // Multiplier core side
  logic                      mul_start;
  logic                      mul_reset;
  logic [DATA_W-1:0]         mul_a;
  logic [DATA_W-1:0]         mul_b;
  logic [PROD_W-1:0]         mul_product;
  logic                      mul_done;

  // Response side
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [PROD_W-1:0]         rsp_product;
  logic                      rsp_error;

  modport slave (
    input  req_valid, req_a, req_b, mul_product, mul_done, rsp_ready,
    output req_ready, mul_start, mul_reset, mul_a, mul_b,
           rsp_valid, rsp_id, rsp_product, rsp_error
  );

  modport master (
    output req_valid, req_a, req_b, mul_product, mul_done, rsp_ready,
    input  req_ready, mul_start, mul_reset, mul_a, mul_b,
           rsp_valid, rsp_id, rsp_product, rsp_error
  );
endinterface

// File: rtl/booth_mult_scheduler.sv
// Round-robin scheduler sharing one signed Booth multiplier core among
// NUM_REQ requesters. One job in flight: grant, start pulse, wait for done
// (or watchdog abort), then present a tagged response until accepted.
module booth_mult_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  booth_mult_scheduler_if.slave bus
);
  localparam int unsigned ID_W   = $clog2(NUM_REQ);
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [ID_W-1:0]    rr_ptr;
  logic [TMR_W-1:0]   timer;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic [ID_W-1:0]    rsp_id_q;
  logic [PROD_W-1:0]  rsp_product_q;
  logic               rsp_error_q;
  logic               rsp_valid_q;
  logic               mul_start_q;
  logic               mul_reset_q;

  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    idx;
  logic [NUM_REQ-1:0] grant;
  logic               xfer;
  logic               done_hit;
  logic               timeout_hit;

  logic [DATA_W-1:0]  lane_a [NUM_REQ];
  logic [DATA_W-1:0]  lane_b [NUM_REQ];

  // Unpack the flat operand buses into per-requester lanes
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane_a[g] = bus.req_a[g*DATA_W +: DATA_W];
    assign lane_b[g] = bus.req_b[g*DATA_W +: DATA_W];
  end

  // Round-robin search: first valid requester starting at rr_ptr
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!win_found && bus.req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic, one-hot grant and watchdog/done decode
  always_comb begin
    next_state  = state;
    grant       = '0;
    xfer        = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        // Grant is masked while reset is asserted so req_ready reads 0
        if (reset_n && win_found) begin
          grant[win_id] = 1'b1;
          xfer          = 1'b1;
          next_state    = ISSUE;
        end
      end
      ISSUE: begin
        next_state = WAIT;
      end
      WAIT: begin
        // A done pulse in the timeout cycle still delivers the real product
        if (bus.mul_done) begin
          done_hit   = 1'b1;
          next_state = RESP;
        end else if (timer == TMR_LAST) begin
          timeout_hit = 1'b1;
          next_state  = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Job capture, round-robin pointer, watchdog timer and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr        <= '0;
      timer         <= '0;
      op_a          <= '0;
      op_b          <= '0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      rsp_error_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      mul_start_q   <= 1'b0;
      mul_reset_q   <= 1'b1;
    end else begin
      mul_start_q <= (next_state == ISSUE);
      rsp_valid_q <= (next_state == RESP);
      mul_reset_q <= timeout_hit;

      if (xfer) begin
        op_a     <= lane_a[win_id];
        op_b     <= lane_b[win_id];
        rsp_id_q <= win_id;
        rr_ptr   <= (win_id == ID_LAST) ? '0 : win_id + ID_W'(1);
      end

      if (state == ISSUE) begin
        timer <= '0;
      end else if (state == WAIT) begin
        timer <= timer + TMR_W'(1);
      end

      if (done_hit) begin
        rsp_product_q <= bus.mul_product;
        rsp_error_q   <= 1'b0;
      end else if (timeout_hit) begin
        rsp_product_q <= '0;
        rsp_error_q   <= 1'b1;
      end
    end
  end

  // Drive the interface
  assign bus.req_ready   = grant;
  assign bus.mul_start   = mul_start_q;
  assign bus.mul_reset   = mul_reset_q;
  assign bus.mul_a       = op_a;
  assign bus.mul_b       = op_b;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_product = rsp_product_q;
  assign bus.rsp_error   = rsp_error_q;
endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Scoreboard bench for booth_mult_scheduler: directed jobs push expected
// starts and responses into queues; a monitor pops and compares them.
module tb_booth_mult_scheduler;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int          LAT     = 3;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] prod;
    logic       err;
  } rsp_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
  } op_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic hang = 1'b0;
  int   total = 0;
  int   bad = 0;

  rsp_t rsp_q[$];
  op_t  op_q[$];

  always #5 clk = ~clk;

  booth_mult_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  booth_mult_scheduler #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Core stub: fixed latency, or silent when hang is set; cleared by mul_reset
  initial begin : core_stub
    int cnt;
    logic signed [7:0] prod;
    cnt = 0;
    prod = '0;
    bus.mul_done = 1'b0;
    bus.mul_product = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mul_done = 1'b0;
      if (bus.mul_reset) begin
        cnt = 0;
      end else if (bus.mul_start && !hang) begin
        cnt = LAT;
        prod = $signed(bus.mul_a) * $signed(bus.mul_b);
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.mul_done = 1'b1;
          bus.mul_product = prod;
        end
      end
    end
  end

  // Monitor: check each start's operands and each accepted response
  initial begin : monitor
    op_t  eo;
    rsp_t er;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.mul_start) begin
          chk("start_expected", (op_q.size() > 0) ? 1 : 0, 1);
          if (op_q.size() > 0) begin
            eo = op_q.pop_front();
            chk("mul_a", int'(bus.mul_a), int'(eo.a));
            chk("mul_b", int'(bus.mul_b), int'(eo.b));
          end
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
          chk("rsp_expected", (rsp_q.size() > 0) ? 1 : 0, 1);
          if (rsp_q.size() > 0) begin
            er = rsp_q.pop_front();
            chk("rsp_id", int'(bus.rsp_id), int'(er.id));
            chk("rsp_product", int'(bus.rsp_product), int'(er.prod));
            chk("rsp_error", int'(bus.rsp_error), int'(er.err));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b);
    bus.req_a[id*DATA_W +: DATA_W] = a;
    bus.req_b[id*DATA_W +: DATA_W] = b;
  endtask

  task automatic expect_job(input int id, input logic [3:0] a, input logic [3:0] b,
                            input logic [7:0] p, input logic e);
    op_t  o;
    rsp_t r;
    o.a = a;
    o.b = b;
    r.id = 2'(id);
    r.prod = p;
    r.err = e;
    op_q.push_back(o);
    rsp_q.push_back(r);
  endtask

  // Wait for requester id to be granted; return just after the transfer edge
  task automatic wait_xfer(input int id);
    int got;
    got = 0;
    for (int c = 0; c < 60 && got == 0; c++) begin
      @(negedge clk);
      if (bus.req_valid[id] && bus.req_ready[id]) got = 1;
    end
    chk("xfer_seen", got, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (rsp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_drained", rsp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Count n_target transfers with valid held, check first grant, then drop
  task automatic run_burst(input int n_target, input logic [3:0] first_grant);
    int n;
    n = 0;
    for (int c = 0; c < 300 && n < n_target; c++) begin
      @(negedge clk);
      if ((bus.req_valid & bus.req_ready) != '0) begin
        if (n == 0) chk("first_grant", int'(bus.req_ready), int'(first_grant));
        chk("grant_onehot", $countones(bus.req_ready), 1);
        n++;
      end
    end
    chk("burst_xfers", n, n_target);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
  endtask

  // Single-requester job with start-to-response latency check
  task automatic one_job(input int id, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] p);
    int t;
    expect_job(id, a, b, p, 1'b0);
    set_req(id, a, b);
    bus.req_valid = 4'(1 << id);
    wait_xfer(id);
    bus.req_valid = '0;
    t = -1;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.rsp_valid && t < 40);
    chk("rsp_latency", t, LAT + 1);
    wait_drain();
  endtask

  initial begin : stimulus
    int t, ts, tv, tr, nres;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;

    // Reset state, with requests pending to show grant is masked
    reset_n = 1'b0;
    bus.req_valid = 4'b0110;
    #12;
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_mul_reset", int'(bus.mul_reset), 1);
    chk("rst_mul_start", int'(bus.mul_start), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_product", int'(bus.rsp_product), 0);
    bus.req_valid = '0;
    #11;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_mul_reset", int'(bus.mul_reset), 0);

    // All four requesting: grants 0,1,2,3,0
    set_req(0, 4'd2, 4'd3);
    set_req(1, 4'hF, 4'd4);
    set_req(2, 4'd5, 4'hD);
    set_req(3, 4'd7, 4'd7);
    expect_job(0, 4'd2, 4'd3, 8'h06, 1'b0);
    expect_job(1, 4'hF, 4'd4, 8'hFC, 1'b0);
    expect_job(2, 4'd5, 4'hD, 8'hF1, 1'b0);
    expect_job(3, 4'd7, 4'd7, 8'h31, 1'b0);
    expect_job(0, 4'd2, 4'd3, 8'h06, 1'b0);
    bus.req_valid = 4'b1111;
    run_burst(5, 4'b0001);
    wait_drain();

    // req0: 3 * -2 = -6
    one_job(0, 4'd3, 4'hE, 8'hFA);

    // Response back-pressure: outputs hold, no grants, no starts
    bus.rsp_ready = 1'b0;
    expect_job(2, 4'hD, 4'd5, 8'hF1, 1'b0);
    set_req(2, 4'hD, 4'd5);
    bus.req_valid = 4'b0100;
    wait_xfer(2);
    bus.req_valid = '0;
    t = 0;
    while (!bus.rsp_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("hold_rsp_seen", int'(bus.rsp_valid), 1);
    @(posedge clk);
    #1;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_rsp_valid", int'(bus.rsp_valid), 1);
      chk("hold_rsp_id", int'(bus.rsp_id), 2);
      chk("hold_rsp_product", int'(bus.rsp_product), 8'hF1);
      chk("hold_rsp_error", int'(bus.rsp_error), 0);
      chk("hold_req_ready", int'(bus.req_ready), 0);
      chk("hold_mul_start", int'(bus.mul_start), 0);
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    wait_drain();

    // Hung core: watchdog abort after TIMEOUT cycles in WAIT
    hang = 1'b1;
    expect_job(3, 4'd1, 4'd1, 8'h00, 1'b1);
    set_req(3, 4'd1, 4'd1);
    bus.req_valid = 4'b1000;
    wait_xfer(3);
    bus.req_valid = '0;
    t = 0; ts = -1; tv = -1; tr = -1; nres = 0;
    while (t < 60 && !(tv >= 0 && t > tv + 3)) begin
      @(negedge clk);
      if (bus.mul_start && ts < 0) ts = t;
      if (bus.mul_reset) begin
        nres++;
        if (tr < 0) tr = t;
      end
      if (bus.rsp_valid && tv < 0) tv = t;
      t++;
    end
    chk("timeout_latency", tv - ts, TIMEOUT + 1);
    chk("timeout_mul_reset_at", tr - ts, TIMEOUT + 1);
    chk("timeout_mul_reset_cycles", nres, 1);
    hang = 1'b0;
    wait_drain();

    // Corner products
    one_job(1, 4'h8, 4'h8, 8'h40);
    one_job(2, 4'h8, 4'd7, 8'hC8);
    one_job(3, 4'd0, 4'd5, 8'h00);

    // Reset while waiting: silent abort, then pointer restarts at 0
    begin
      op_t o;
      o.a = 4'd2;
      o.b = 4'd2;
      op_q.push_back(o);
    end
    set_req(2, 4'd2, 4'd2);
    bus.req_valid = 4'b0100;
    wait_xfer(2);
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    bus.req_valid = 4'b0110;
    #1;
    chk("midrst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("midrst_mul_start", int'(bus.mul_start), 0);
    chk("midrst_mul_reset", int'(bus.mul_reset), 1);
    chk("midrst_req_ready", int'(bus.req_ready), 0);
    chk("midrst_mul_a", int'(bus.mul_a), 0);
    set_req(1, 4'hE, 4'hD);
    set_req(2, 4'd4, 4'hC);
    expect_job(1, 4'hE, 4'hD, 8'h06, 1'b0);
    expect_job(2, 4'd4, 4'hC, 8'hF0, 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    run_burst(2, 4'b0010);
    wait_drain();

    repeat (5) @(negedge clk);
    chk("start_q_empty", op_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
